// File: rtl/fdivcnt_pkg.sv
// Shared definitions for the fdivcnt programmable divider slice.
//   DEFAULT_WIDTH : default width of the count/reload registers.
package fdivcnt_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage : fdivcnt_pkg

// File: rtl/fdivcnt_cp_edge.sv
// cp_edge: rising-edge detector for an emulated clock sampled in the
// sys_clk domain. Reusable by every emulated-clock cell.
// Ports:
//   sys_clk : system oversampling clock (rising edge)
//   cd      : asynchronous active-low clear
//   cp      : emulated clock level, sampled on sys_clk
//   evt     : high for the sys_clk cycle in which cp is first seen high
module cp_edge (
  input  logic sys_clk,
  input  logic cd,
  input  logic cp,
  output logic evt
);

  logic r_cp_prev;

  // Clearing to 1 means a cp already high at reset release is not an edge;
  // cp must be seen low first.
  always_ff @(posedge sys_clk or negedge cd) begin
    if (!cd) begin
      r_cp_prev <= 1'b1;
    end else begin
      r_cp_prev <= cp;
    end
  end

  assign evt = ~r_cp_prev & cp;

endmodule : cp_edge

// File: rtl/fdivcnt.sv
// fdivcnt: programmable divide-by-(reload+1) stage clocked by rising edges
// of an emulated clock cp, with all state held in the sys_clk domain.
// Ports:
//   sys_clk : system oversampling clock (rising edge)
//   cd      : asynchronous active-low clear
//   cp      : emulated clock; only its rising edges are events
//   ld      : load strobe (q and reload <= d), qualified by a cp edge
//   en      : count enable, qualified by a cp edge
//   d       : reload value
//   q       : current count
//   co      : divided clock, toggles on each terminal reload
//   tc      : terminal-count strobe, one sys_clk cycle wide
module fdivcnt
  import fdivcnt_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             sys_clk,
  input  logic             cd,
  input  logic             cp,
  input  logic             ld,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             co,
  output logic             tc
);

  logic             w_evt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_rld;
  logic             r_co;
  logic             r_tc;

  cp_edge u_cp_edge (
    .sys_clk (sys_clk),
    .cd      (cd),
    .cp      (cp),
    .evt     (w_evt)
  );

  // tc defaults low every cycle so it can only ever be a single-cycle pulse.
  // Load outranks the terminal reload: no co toggle and no tc on a load.
  always_ff @(posedge sys_clk or negedge cd) begin
    if (!cd) begin
      r_q   <= '0;
      r_rld <= '0;
      r_co  <= 1'b0;
      r_tc  <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      if (w_evt) begin
        if (ld) begin
          r_q   <= d;
          r_rld <= d;
        end else if (en) begin
          if (r_q == '0) begin
            r_q  <= r_rld;
            r_co <= ~r_co;
            r_tc <= 1'b1;
          end else begin
            r_q <= r_q - WIDTH'(1);
          end
        end
      end
    end
  end

  assign q  = r_q;
  assign co = r_co;
  assign tc = r_tc;

endmodule : fdivcnt

// File: tb/tb_fdivcnt.sv
// Directed bench for fdivcnt. The stimulus tasks know when they create a cp
// rising edge, so the reference model updates only on those events; a
// negedge process compares every cycle, and literal checks pin the model.
module tb_fdivcnt;

  localparam int unsigned W = 8;

  logic         sys_clk = 1'b0;
  logic         cd;
  logic         cp;
  logic         ld;
  logic         en;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic         co;
  logic         tc;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [W-1:0] m_q   = '0;
  logic [W-1:0] m_rld = '0;
  logic         m_co  = 1'b0;
  logic         m_tc  = 1'b0;

  fdivcnt #(.WIDTH(W)) dut (
    .sys_clk (sys_clk),
    .cd      (cd),
    .cp      (cp),
    .ld      (ld),
    .en      (en),
    .d       (d),
    .q       (q),
    .co      (co),
    .tc      (tc)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge sys_clk) begin
    check("model_q",  int'(q),  int'(m_q));
    check("model_co", int'(co), int'(m_co));
    check("model_tc", int'(tc), int'(m_tc));
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
    m_tc = 1'b0;
  endtask

  // cp held at its level; ld/en/d toggled with junk that must be ignored
  task automatic cp_hold(input int n);
    for (int i = 0; i < n; i++) begin
      ld = 1'b1;
      en = 1'b1;
      d  = W'($urandom);
      tick();
    end
  endtask

  // One full cp period: low cycle, rising-edge cycle with the given controls,
  // then a high cycle. DUT outputs right after the edge are returned.
  task automatic cp_pulse(input logic l, input logic e, input logic [W-1:0] dv,
                          output logic [W-1:0] oq, output logic oco,
                          output logic otc);
    cp = 1'b0;
    cp_hold(1);
    cp = 1'b1;
    ld = l;
    en = e;
    d  = dv;
    tick();
    if (l) begin
      m_q   = dv;
      m_rld = dv;
    end else if (e) begin
      if (m_q == 0) begin
        m_q  = m_rld;
        m_co = ~m_co;
        m_tc = 1'b1;
      end else begin
        m_q = m_q - 1;
      end
    end
    oq  = q;
    oco = co;
    otc = tc;
    cp_hold(1);
  endtask

  int           exp_q  [8] = '{2, 1, 0, 3, 2, 1, 0, 3};
  int           exp_co [8] = '{0, 0, 0, 1, 1, 1, 1, 0};
  int           exp_tc [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
  logic [W-1:0] sq;
  logic         sco;
  logic         stc;

  initial begin
    cd = 1'b0;
    cp = 1'b1;
    ld = 1'b0;
    en = 1'b0;
    d  = '0;
    tick();
    tick();
    check("rst_q",  int'(q),  0);
    check("rst_co", int'(co), 0);
    check("rst_tc", int'(tc), 0);

    // release with cp high: holding it high must not count
    cd = 1'b1;
    cp_hold(5);
    check("hold_high_q", int'(q), 0);

    // load 3, then eight enabled edges
    cp_pulse(1'b1, 1'b0, 8'd3, sq, sco, stc);
    check("load3_q", int'(sq), 3);
    for (int i = 0; i < 8; i++) begin
      cp_pulse(1'b0, 1'b1, 8'd0, sq, sco, stc);
      check($sformatf("div4_q%0d", i),  int'(sq),  exp_q[i]);
      check($sformatf("div4_co%0d", i), int'(sco), exp_co[i]);
      check($sformatf("div4_tc%0d", i), int'(stc), exp_tc[i]);
    end

    // reload 0: cp/2
    cp_pulse(1'b1, 1'b1, 8'd0, sq, sco, stc);
    check("load0_tc", int'(stc), 0);
    for (int i = 0; i < 6; i++) begin
      cp_pulse(1'b0, 1'b1, 8'd0, sq, sco, stc);
      check($sformatf("div1_co%0d", i), int'(sco), (i % 2 == 0) ? 1 : 0);
      check($sformatf("div1_tc%0d", i), int'(stc), 1);
    end

    // load at terminal count wins
    cp_pulse(1'b1, 1'b1, 8'd5, sq, sco, stc);
    check("ldwin_q",  int'(sq),  5);
    check("ldwin_co", int'(sco), 0);
    check("ldwin_tc", int'(stc), 0);
    for (int i = 0; i < 6; i++) cp_pulse(1'b0, 1'b1, 8'd0, sq, sco, stc);
    check("div6_q",  int'(sq),  5);
    check("div6_co", int'(sco), 1);

    // reload 4, count to 2, then clear mid-count
    cp_pulse(1'b1, 1'b0, 8'd4, sq, sco, stc);
    cp_pulse(1'b0, 1'b1, 8'd0, sq, sco, stc);
    cp_pulse(1'b0, 1'b1, 8'd0, sq, sco, stc);
    check("pre_rst_q", int'(sq), 2);
    #2;
    cd    = 1'b0;
    m_q   = '0;
    m_rld = '0;
    m_co  = 1'b0;
    m_tc  = 1'b0;
    #1;
    check("async_q",  int'(q),  0);
    check("async_co", int'(co), 0);
    check("async_tc", int'(tc), 0);
    tick();
    tick();
    cd = 1'b1;
    cp_hold(5);
    check("post_rst_hold_q", int'(q), 0);
    // reload is 0 after clear, so the first real edge is terminal
    cp_pulse(1'b0, 1'b1, 8'd0, sq, sco, stc);
    check("post_rst_co", int'(sco), 1);
    check("post_rst_tc", int'(stc), 1);

    // enable gating mid-count
    cp_pulse(1'b1, 1'b0, 8'd9, sq, sco, stc);
    cp_pulse(1'b0, 1'b1, 8'd0, sq, sco, stc);
    cp_pulse(1'b0, 1'b1, 8'd0, sq, sco, stc);
    check("en_q7", int'(sq), 7);
    for (int i = 0; i < 3; i++) begin
      cp_pulse(1'b0, 1'b0, 8'd0, sq, sco, stc);
      check($sformatf("en0_q%0d", i),  int'(sq),  7);
      check($sformatf("en0_tc%0d", i), int'(stc), 0);
    end
    cp_pulse(1'b0, 1'b1, 8'd0, sq, sco, stc);
    check("reen_q", int'(sq), 6);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_fdivcnt
